// File: rtl/eth_pkt_arb.sv
// Packet-granular round-robin arbiter: NPORT ingress requesters share one output
// beat register. Ownership is held from SOP to EOP, and every packet passes through an IDLE arbitration cycle.
module eth_pkt_arb #(
  parameter int          NPORT        = 4,
  parameter int          DW           = 64,
  parameter logic [31:0] PKT_CNT_INIT = 32'd0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPORT*DW-1:0] req_data,
  input  logic [NPORT-1:0]    req_sop,
  input  logic [NPORT-1:0]    req_eop,
  input  logic [NPORT-1:0]    req_vld,
  output logic [NPORT-1:0]    req_rdy,
  output logic [DW-1:0]       inData,
  output logic                inSop,
  output logic                inEop,
  output logic                vld,
  input  logic                out_rdy,
  output logic [NPORT-1:0]    grant,
  output logic [31:0]         pkt_cnt,
  output logic                err_sop
);

  localparam int IW = $clog2(NPORT);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, stateNext;

  logic [DW-1:0]    portData [NPORT];
  logic [NPORT-1:0] request;
  logic [IW-1:0]    lastGrant, gIdx, pickIdx;
  logic             pickValid, firstBeat, accept, acceptEop, outXfer, portRdy;

  for (genvar i = 0; i < NPORT; i++) begin : gSplit
    assign portData[i] = req_data[i*DW +: DW];
  end

  assign request   = req_vld & req_sop;
  assign portRdy   = ~vld | out_rdy;
  assign accept    = (state == BUSY) & req_vld[gIdx] & portRdy;
  assign acceptEop = accept & req_eop[gIdx];
  assign outXfer   = vld & out_rdy;

  // Scan from the farthest port back to lastGrant+1 so the nearest requester is written last and wins.
  always_comb begin
    pickIdx   = '0;
    pickValid = 1'b0;
    for (int k = NPORT; k >= 1; k--) begin
      if (request[IW'((int'(lastGrant) + k) % NPORT)]) begin
        pickIdx   = IW'((int'(lastGrant) + k) % NPORT);
        pickValid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    req_rdy   = '0;
    case (state)
      IDLE: if (pickValid) stateNext = BUSY;
      BUSY: begin
        req_rdy[gIdx] = portRdy;
        if (acceptEop) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Grant is loaded on the same edge that enters BUSY and released on the edge that accepts EOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= '0;
      gIdx      <= '0;
      lastGrant <= IW'(NPORT - 1);
      firstBeat <= 1'b0;
    end else if (state == IDLE) begin
      if (pickValid) begin
        grant     <= {{(NPORT-1){1'b0}}, 1'b1} << pickIdx;
        gIdx      <= pickIdx;
        firstBeat <= 1'b1;
      end
    end else if (accept) begin
      firstBeat <= 1'b0;
      if (req_eop[gIdx]) begin
        grant     <= '0;
        lastGrant <= gIdx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inData  <= '0;
      inSop   <= 1'b0;
      inEop   <= 1'b0;
      vld     <= 1'b0;
      pkt_cnt <= PKT_CNT_INIT;
      err_sop <= 1'b0;
    end else begin
      if (accept) begin
        inData <= portData[gIdx];
        inSop  <= req_sop[gIdx];
        inEop  <= req_eop[gIdx];
        vld    <= 1'b1;
      end else if (outXfer) begin
        vld <= 1'b0;
      end
      if (outXfer && inEop) pkt_cnt <= pkt_cnt + 32'd1;
      err_sop <= accept & req_sop[gIdx] & ~firstBeat;
    end
  end

endmodule

// File: tb/tb_eth_pkt_arb.sv
// Bench for eth_pkt_arb: per-port beat buffers feed the DUT, and a packet/ownership model
// (round-robin picks, FIFO of accepted beats, EOP counter) is compared against the outputs every cycle.
module tb_eth_pkt_arb;

  localparam int NPORT = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 1024;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NPORT*DW-1:0] req_data = '0;
  logic [NPORT-1:0]    req_sop = '0, req_eop = '0, req_vld = '0;
  logic [NPORT-1:0]    req_rdy, grant;
  logic [DW-1:0]       inData;
  logic                inSop, inEop, vld, err_sop;
  logic                out_rdy = 1'b1;
  logic [31:0]         pkt_cnt;

  logic [NPORT-1:0]    wVld = '0, wRdy, wGrant;
  logic [NPORT*DW-1:0] wReqData = '0;
  logic [DW-1:0]       wData;
  logic                wSop, wEop, wValid, wErr;
  logic [31:0]         wPktCnt;

  always #5 clk = ~clk;

  eth_pkt_arb #(.NPORT(NPORT), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_sop(req_sop), .req_eop(req_eop),
    .req_vld(req_vld), .req_rdy(req_rdy), .inData(inData), .inSop(inSop), .inEop(inEop),
    .vld(vld), .out_rdy(out_rdy), .grant(grant), .pkt_cnt(pkt_cnt), .err_sop(err_sop)
  );

  // Second instance with the counter starting just below wrap; port 0 sends single-beat packets.
  eth_pkt_arb #(.NPORT(NPORT), .DW(DW), .PKT_CNT_INIT(32'hFFFF_FFFF)) dutWrap (
    .clk(clk), .reset(reset), .req_data(wReqData), .req_sop(wVld), .req_eop(wVld),
    .req_vld(wVld), .req_rdy(wRdy), .inData(wData), .inSop(wSop), .inEop(wEop),
    .vld(wValid), .out_rdy(1'b1), .grant(wGrant), .pkt_cnt(wPktCnt), .err_sop(wErr)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  int testsRun = 0;
  int testsFailed = 0;
  int cycle = 0;
  int rdyMode = 0;
  int wSent = 0;
  int wTarget = 0;

  logic [DW-1:0] bufData [NPORT][DEPTH];
  logic          bufSop  [NPORT][DEPTH];
  logic          bufEop  [NPORT][DEPTH];
  int            wrPtr   [NPORT];
  int            rdPtr   [NPORT];

  beat_t       mQ[$];
  int          mOwner = -1;
  int          mLast = NPORT - 1;
  logic [31:0] mCnt = '0;
  logic        mErr = 1'b0;
  bit          mFirst = 1'b0;
  bit          checkEn = 1'b0;

  int               grantLog[$];
  int               grantCyc[$];
  int               errCount = 0;
  int               outXfers = 0;
  logic [NPORT-1:0] prevGrant = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int rrPick(input logic [NPORT-1:0] r, input int last);
    for (int k = 1; k <= NPORT; k++) begin
      int p;
      p = (last + k) % NPORT;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  function automatic int logAt(input int i);
    return (i < grantLog.size()) ? grantLog[i] : -1;
  endfunction

  function automatic int cycAt(input int i);
    return (i < grantCyc.size()) ? grantCyc[i] : -1000;
  endfunction

  function automatic bit allEmpty();
    for (int i = 0; i < NPORT; i++) if (rdPtr[i] != wrPtr[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Every cycle: compare outputs against the model, then advance the model with the inputs held for the coming edge.
  initial begin
    forever begin
      logic [NPORT-1:0] expRdy, expGrant;
      logic             acc, nextErr;
      int               pick;
      @(negedge clk);
      expRdy   = '0;
      expGrant = '0;
      if (mOwner >= 0) begin
        expGrant[mOwner] = 1'b1;
        if (mQ.size() == 0 || out_rdy) expRdy[mOwner] = 1'b1;
      end
      if (checkEn) begin
        checkOutput("grant", grant, expGrant);
        checkOutput("req_rdy", req_rdy, expRdy);
        checkOutput("vld", vld, mQ.size() != 0);
        if (vld && mQ.size() != 0) begin
          checkOutput("inData", inData, mQ[0].data);
          checkOutput("inSopEop", {inSop, inEop}, {mQ[0].sop, mQ[0].eop});
        end
        checkOutput("pkt_cnt", pkt_cnt, mCnt);
        checkOutput("err_sop", err_sop, mErr);
        if (grant != '0 && prevGrant == '0) begin
          for (int i = 0; i < NPORT; i++) if (grant[i]) grantLog.push_back(i);
          grantCyc.push_back(cycle);
        end
        if (err_sop === 1'b1) errCount++;
        if (vld && out_rdy) outXfers++;
      end
      prevGrant = grant;

      if (reset) begin
        mQ.delete();
        mOwner = -1;
        mLast  = NPORT - 1;
        mCnt   = '0;
        mErr   = 1'b0;
        mFirst = 1'b0;
      end else begin
        nextErr = 1'b0;
        acc = (mOwner >= 0) && req_vld[mOwner] && expRdy[mOwner];
        if (mQ.size() != 0 && out_rdy) begin
          if (mQ[0].eop) mCnt = mCnt + 32'd1;
          void'(mQ.pop_front());
        end
        if (mOwner >= 0) begin
          if (acc) begin
            nextErr = req_sop[mOwner] && !mFirst;
            mQ.push_back({req_data[mOwner*DW +: DW], req_sop[mOwner], req_eop[mOwner]});
            mFirst = 1'b0;
            if (req_eop[mOwner]) begin
              mLast  = mOwner;
              mOwner = -1;
            end
          end
        end else begin
          pick = rrPick(req_vld & req_sop, mLast);
          if (pick >= 0) begin
            mOwner = pick;
            mFirst = 1'b1;
          end
        end
        mErr = nextErr;
      end
    end
  end

  task automatic drivePorts();
    for (int i = 0; i < NPORT; i++) begin
      if (rdPtr[i] != wrPtr[i]) begin
        req_vld[i] = 1'b1;
        req_sop[i] = bufSop[i][rdPtr[i] % DEPTH];
        req_eop[i] = bufEop[i][rdPtr[i] % DEPTH];
        req_data[i*DW +: DW] = bufData[i][rdPtr[i] % DEPTH];
      end else begin
        req_vld[i] = 1'b0;
        req_sop[i] = 1'b0;
        req_eop[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
    case (rdyMode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = (cycle % 4 == 0) || (cycle % 4 == 3);
      default: out_rdy = ($urandom_range(0, 3) != 0);
    endcase
    wVld    = '0;
    wVld[0] = (wSent < wTarget);
  endtask

  task automatic applyStimulus();
    logic [NPORT-1:0] xfer;
    logic             wX;
    @(negedge clk);
    xfer = req_vld & req_rdy;
    wX   = wVld[0] & wRdy[0];
    @(posedge clk);
    #1;
    cycle++;
    for (int i = 0; i < NPORT; i++) if (xfer[i]) rdPtr[i]++;
    if (wX) wSent++;
    drivePorts();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic pushPkt(input int port, input int len, input int strayAt, input bit noSop);
    for (int b = 0; b < len; b++) begin
      int idx;
      idx = wrPtr[port] % DEPTH;
      bufData[port][idx] = {$urandom, $urandom};
      bufSop[port][idx]  = ((b == 0) && !noSop) || ((b == strayAt) && (b > 0));
      bufEop[port][idx]  = (b == len - 1);
      wrPtr[port]++;
    end
  endtask

  task automatic flushAll();
    for (int i = 0; i < NPORT; i++) begin
      rdPtr[i] = 0;
      wrPtr[i] = 0;
    end
  endtask

  task automatic waitDrain(input int budget, input string name);
    int n;
    n = 0;
    while (!allEmpty() && n < budget) begin
      applyStimulus();
      n++;
    end
    if (!allEmpty()) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: beats still pending after %0d cycles, expected all accepted", name, budget);
      flushAll();
      drivePorts();
    end
    runCycles(6);
  endtask

  task automatic doReset();
    reset   = 1'b1;
    wSent   = 0;
    wTarget = 0;
    flushAll();
    drivePorts();
    runCycles(2);
    reset = 1'b0;
    grantLog.delete();
    grantCyc.delete();
    errCount = 0;
    outXfers = 0;
    checkEn  = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    flushAll();
    drivePorts();
    doReset();
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_req_rdy", req_rdy, 0);
    checkOutput("rst_vld", vld, 0);
    checkOutput("rst_sop_eop", {inSop, inEop}, 0);
    checkOutput("rst_inData", inData, 0);
    checkOutput("rst_pkt_cnt", pkt_cnt, 0);
    checkOutput("rst_err_sop", err_sop, 0);
    checkOutput("rst_wrap_outputs", {wGrant, wValid, wErr, wSop, wEop}, 0);
    checkOutput("rst_wrap_data", wData, 0);
    checkOutput("rst_wrap_cnt", wPktCnt, 32'hFFFF_FFFF);

    wTarget = 1;
    runCycles(8);
    checkOutput("wrap_first_eop", wPktCnt, 32'h0000_0000);
    wTarget = 2;
    runCycles(8);
    checkOutput("wrap_second_eop", wPktCnt, 32'h0000_0001);

    // Two simultaneous 3-beat packets: port 0 wins after reset, port 2 follows.
    doReset();
    pushPkt(0, 3, 0, 0);
    pushPkt(2, 3, 0, 0);
    waitDrain(100, "two_port_drain");
    checkOutput("two_port_first", logAt(0), 0);
    checkOutput("two_port_second", logAt(1), 2);
    checkOutput("two_port_cnt", pkt_cnt, 2);

    // All ports streaming single-beat packets rotate 0,1,2,3 at two cycles per packet.
    doReset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NPORT; p++) pushPkt(p, 1, 0, 0);
    waitDrain(200, "rr_drain");
    for (int i = 0; i < 6; i++) checkOutput($sformatf("rr_order%0d", i), logAt(i), i % NPORT);
    checkOutput("rr_spacing", cycAt(5) - cycAt(0), 10);
    checkOutput("rr_cnt", pkt_cnt, 8);

    // Backpressure on a 4-beat packet: each beat leaves exactly once.
    doReset();
    rdyMode = 1;
    pushPkt(1, 4, 0, 0);
    waitDrain(100, "stall_drain");
    checkOutput("stall_out_beats", outXfers, 4);
    checkOutput("stall_cnt", pkt_cnt, 1);
    rdyMode = 0;

    // Stray SOP inside port 3's packet while port 0 waits.
    doReset();
    pushPkt(3, 4, 2, 0);
    runCycles(2);
    pushPkt(0, 1, 0, 0);
    waitDrain(100, "stray_sop_drain");
    checkOutput("stray_err_count", errCount, 1);
    checkOutput("stray_owner", logAt(0), 3);
    checkOutput("stray_next_owner", logAt(1), 0);
    checkOutput("stray_cnt", pkt_cnt, 2);

    // A valid beat without SOP in IDLE is ignored.
    doReset();
    pushPkt(2, 1, 0, 1);
    runCycles(5);
    checkOutput("nonsop_no_grant", grantLog.size(), 0);
    checkOutput("nonsop_no_err", errCount, 0);
    flushAll();
    drivePorts();

    // Reset during beat 2 of a 5-beat packet.
    doReset();
    pushPkt(0, 1, 0, 0);
    waitDrain(50, "pre_abort_drain");
    checkOutput("pre_abort_cnt", pkt_cnt, 1);
    pushPkt(2, 5, 0, 0);
    n = 0;
    while (rdPtr[2] < 1 && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("abort_first_beat_taken", rdPtr[2] >= 1, 1);
    reset = 1'b1;
    applyStimulus();
    checkOutput("abort_grant", grant, 0);
    checkOutput("abort_vld", vld, 0);
    checkOutput("abort_cnt", pkt_cnt, 0);
    flushAll();
    reset = 1'b0;
    drivePorts();
    grantLog.delete();
    pushPkt(1, 3, 0, 0);
    waitDrain(100, "post_abort_drain");
    checkOutput("post_abort_owner", logAt(0), 1);
    checkOutput("post_abort_cnt", pkt_cnt, 1);

    // Randomized traffic, random backpressure, stray SOPs and occasional resets.
    doReset();
    rdyMode = 2;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NPORT; p++)
        if (rdPtr[p] == wrPtr[p] && $urandom_range(0, 3) == 0)
          pushPkt(p, $urandom_range(1, 5), ($urandom_range(0, 7) == 0) ? 1 : 0, 0);
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        applyStimulus();
        flushAll();
        reset = 1'b0;
        drivePorts();
      end
      applyStimulus();
    end
    rdyMode = 0;
    waitDrain(500, "random_drain");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/eth_pkt_arb.md
ETH_PKT_ARB -- requirements
Module: eth_pkt_arb

Interface
REQ-001 Parameter NPORT, default 4, number of ingress requesters (2..8).
REQ-002 Parameter DW, default 64, data beat width in bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_data  input  NPORT*DW  per-port data beat; port i occupies bits [i*DW +: DW].
REQ-006 req_sop  input  NPORT  per-port start-of-packet marker.
REQ-007 req_eop  input  NPORT  per-port end-of-packet marker.
REQ-008 req_vld  input  NPORT  per-port beat valid.
REQ-009 req_rdy  output  NPORT  per-port beat accept; a beat transfers when req_vld[i] & req_rdy[i].
REQ-010 inData  output  DW  arbitrated data beat toward the switch datapath.
REQ-011 inSop / inEop  output  1 each  SOP/EOP of the current output beat.
REQ-012 vld  output  1  output beat valid.
REQ-013 out_rdy  input  1  downstream accept; an output beat transfers when vld & out_rdy.
REQ-014 grant  output  NPORT  one-hot owner of the output; all-zero when idle.
REQ-015 pkt_cnt  output  32  count of packets forwarded (EOP beats transferred out).
REQ-016 err_sop  output  1  one-cycle pulse on a protocol violation (see REQ-027).

Function
REQ-017 FSM has two states: IDLE and BUSY.
REQ-018 IDLE: request[i] = req_vld[i] & req_sop[i]; req_rdy is all-zero.
REQ-019 IDLE with any request: choose the first requesting port scanning upward (modulo NPORT) from last_grant+1. Load grant one-hot, then enter BUSY on the next edge.
REQ-020 IDLE with no request: remain in IDLE; grant stays all-zero.
REQ-021 BUSY: req_rdy[g] = ~vld | out_rdy for granted port g; all other req_rdy bits are 0.
REQ-022 Each accepted beat is registered into inData/inSop/inEop with vld=1 on the next edge, giving fixed 1-cycle latency.
REQ-023 The output register holds its contents while vld & ~out_rdy. vld clears when an output transfer occurs and no new beat is accepted in the same cycle.
REQ-024 Accepting a beat with req_eop=1 in BUSY: set last_grant=g, clear grant, and return to IDLE on the same edge. Every packet therefore incurs at least one IDLE arbitration cycle.
REQ-025 A single-beat packet (sop & eop together) is accepted as one transfer and follows REQ-024.
REQ-026 Ownership is packet-granular: no grant change is permitted between SOP and EOP, regardless of other requests.
REQ-027 BUSY beat accepted with req_sop=1 that is not the packet's first beat: err_sop pulses for one cycle and the beat is still forwarded unchanged.
REQ-028 In IDLE, a port with vld & ~sop is not a request; it receives no req_rdy and no error is flagged.
REQ-029 pkt_cnt increments by 1 on each output transfer with inEop=1 and wraps from 0xFFFFFFFF to 0.
REQ-030 Round-robin fairness: with all NPORT ports continuously requesting, grants rotate 0,1,...,NPORT-1,0 in that order.
REQ-031 Requesters must hold req_vld/data stable until req_rdy; the block never drops an accepted beat.

Reset
REQ-032 reset=1 at a clock edge forces: state=IDLE, grant=0, req_rdy=0, vld=0, inSop=0, inEop=0, inData=0, pkt_cnt=0, err_sop=0, last_grant=NPORT-1 (so port 0 wins first).
REQ-033 Reset asserted mid-packet aborts the packet; the partial packet is not completed and pkt_cnt is not incremented.
REQ-034 Reset has priority over every other event in the same cycle.

Verification
REQ-035 After reset, ports 0 and 2 present 3-beat packets simultaneously, out_rdy=1 -> port 0 is granted first. Its beats appear on inData 1 cycle after each acceptance, then port 2's packet follows; pkt_cnt=2.
REQ-036 All 4 ports continuously offer 1-beat packets, out_rdy=1 -> grant order 0,1,2,3,0,1. Each packet costs 2 cycles (IDLE + BUSY).
REQ-037 Port 1 sends a 4-beat packet while out_rdy toggles 1,0,0,1,... -> output beats are held and never duplicated or lost. req_rdy[1] drops whenever vld & ~out_rdy.
REQ-038 Port 3 mid-packet presents a beat with sop=1 -> err_sop pulses exactly once, the beat is forwarded, and grant remains on port 3 until EOP.
REQ-039 pkt_cnt preloaded near 0xFFFFFFFF via 2 packets -> counter wraps to 0x00000001 after the second EOP.
REQ-040 reset asserted during beat 2 of a 5-beat packet -> next cycle grant=0, vld=0, pkt_cnt=0; a new SOP on port 1 is then granted normally.
